// File: rtl/cmd_parser.sv
// cmd_parser - multi-key command parser for the host UART byte stream.
//
// A packet is one key character, an optional unsigned argument and a line
// terminator (LF or CR). On the terminator the parser issues a one-cycle
// command strobe carrying the key index and the argument value. A keyed
// packet that is malformed or overflows produces a one-cycle error strobe.
// Packets that start with any other byte are skipped up to the next terminator.
//
// Parameters:
//   NUM_KEYS     number of recognised keys (1..16)
//   KEYS         packed key characters, key i = KEYS[8*i +: 8]
//   VALUE_WIDTH  argument width in bits (4..32)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   in_byte  in   received byte, sampled when latch=1
//   latch    in   one-cycle strobe marking in_byte valid
//   match    out  one-hot command strobe (index = matched key)
//   valid    out  one-cycle strobe, asserted together with match
//   value    out  parsed argument, updated with valid, held otherwise
//   error    out  one-cycle strobe, keyed packet ended malformed
//
// Build option:
//   CMD_PARSER_HEX_EN  when defined, an "x" as the first argument byte
//                      switches the argument to hexadecimal.
module cmd_parser #(
  parameter int                    NUM_KEYS    = 4,
  parameter logic [8*NUM_KEYS-1:0] KEYS        = "dcba",
  parameter int                    VALUE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_byte,
  input  logic                   latch,
  output logic [NUM_KEYS-1:0]    match,
  output logic                   valid,
  output logic [VALUE_WIDTH-1:0] value,
  output logic                   error
);

  // Four spare bits hold acc*10+digit (or acc*16+nibble) for any in-range acc.
  localparam int ACC_W = VALUE_WIDTH + 4;
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_ARG    = 2'd1,
    S_IGNORE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             err_reg;
  logic [IDX_W-1:0] key_idx_reg;

  // Byte classification
  logic [NUM_KEYS-1:0] key_hit;
  logic                key_any;
  logic [IDX_W-1:0]    key_idx;
  logic                is_term;
  logic                is_dec;
  logic                digit_ok;
  logic [3:0]          nib;
  logic [ACC_W-1:0]    acc_scaled;
  logic [ACC_W-1:0]    acc_sum;
  logic                overflow;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      assign key_hit[gi] = (in_byte == KEYS[8*gi +: 8]);
    end
  endgenerate

  // Walk downwards so that with duplicate keys the lowest index wins.
  always_comb begin
    key_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_hit[i]) key_idx = IDX_W'(i);
    end
  end

  assign key_any = |key_hit;
  assign is_term = (in_byte == 8'd10) || (in_byte == 8'd13);
  assign is_dec  = (in_byte >= "0") && (in_byte <= "9");

`ifdef CMD_PARSER_HEX_EN
  logic hex_mode_reg;
  logic first_reg;    // no argument byte seen yet in this packet
  logic is_hex_alpha;

  assign is_hex_alpha = ((in_byte >= "a") && (in_byte <= "f")) ||
                        ((in_byte >= "A") && (in_byte <= "F"));
  assign digit_ok   = hex_mode_reg ? (is_dec || is_hex_alpha) : is_dec;
  // Letters a-f/A-F have low nibble 1..6, so +9 gives 10..15.
  assign nib        = is_dec ? in_byte[3:0] : (in_byte[3:0] + 4'd9);
  assign acc_scaled = hex_mode_reg ? (acc_reg << 4) : (acc_reg * ACC_W'(10));
`else
  assign digit_ok   = is_dec;
  assign nib        = in_byte[3:0];
  assign acc_scaled = acc_reg * ACC_W'(10);
`endif

  assign acc_sum  = acc_scaled + ACC_W'(nib);
  assign overflow = |acc_sum[ACC_W-1:VALUE_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_WAIT;
      acc_reg     <= '0;
      err_reg     <= 1'b0;
      key_idx_reg <= '0;
      match       <= '0;
      valid       <= 1'b0;
      value       <= '0;
      error       <= 1'b0;
`ifdef CMD_PARSER_HEX_EN
      hex_mode_reg <= 1'b0;
      first_reg    <= 1'b0;
`endif
    end else begin
      match <= '0;
      valid <= 1'b0;
      error <= 1'b0;
      if (latch) begin
        case (state_reg)
          S_WAIT: begin
            if (key_any) begin
              state_reg   <= S_ARG;
              key_idx_reg <= key_idx;
              acc_reg     <= '0;
              err_reg     <= 1'b0;
`ifdef CMD_PARSER_HEX_EN
              hex_mode_reg <= 1'b0;
              first_reg    <= 1'b1;
`endif
            end else if (!is_term) begin
              state_reg <= S_IGNORE;
            end
          end
          S_ARG: begin
`ifdef CMD_PARSER_HEX_EN
            first_reg <= 1'b0;
`endif
            if (is_term) begin
              state_reg <= S_WAIT;
              if (err_reg) begin
                error <= 1'b1;
              end else begin
                match <= NUM_KEYS'(1) << key_idx_reg;
                valid <= 1'b1;
                value <= acc_reg[VALUE_WIDTH-1:0];
              end
            end
`ifdef CMD_PARSER_HEX_EN
            else if (first_reg && (in_byte == "x")) begin
              hex_mode_reg <= 1'b1;
            end
`endif
            else if (digit_ok) begin
              // Once flagged, the packet is doomed; stop accumulating.
              if (!err_reg) begin
                if (overflow) err_reg <= 1'b1;
                else          acc_reg <= acc_sum;
              end
            end else begin
              err_reg <= 1'b1;
            end
          end
          S_IGNORE: begin
            if (is_term) state_reg <= S_WAIT;
          end
          default: state_reg <= S_WAIT;
        endcase
      end
    end
  end

endmodule

// File: doc/cmd_parser.md
# cmd_parser

Multi-key command parser for the host UART byte stream. Matches a packet's first byte against a set of key characters, accumulates an unsigned decimal argument, and on the line terminator issues a one-cycle command strobe carrying the key index and argument value. Sits between the UART receiver (byte + `latch` strobe) and the laser-control register/sequencer logic. Generalises the single-key matcher with N keys, a numeric payload and error reporting.

## Interface
- `NUM_KEYS`, 4: number of recognised keys, 1..16.
- `KEYS`, "dcba": packed key characters; key i = `KEYS[8*i +: 8]`, so key 0 = "a".
- `VALUE_WIDTH`, 16: argument width in bits, 4..32.

- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_byte`  in  8  received byte; sampled only when `latch`=1.
- `latch`  in  1  one-cycle strobe: `in_byte` valid.
- `match`  out  NUM_KEYS  one-hot command strobe, one cycle, index = matched key.
- `valid`  out  1  one-cycle strobe, asserted with `match`.
- `value`  out  VALUE_WIDTH  parsed argument; updated with `valid`, held otherwise.
- `error`  out  1  one-cycle strobe: a keyed packet ended malformed.

## Operation
- Terminator: byte 10 or 13. Digit: "0".."9". All other bytes non-digit.
- States:
  - WAIT: latched key byte -> ARG, capture key index, clear accumulator, clear err flag. Latched terminator -> stay WAIT (covers CR-LF). Other byte -> IGNORE (packet for another block, no error).
  - ARG: latched digit -> acc = acc*10 + digit. Latched terminator -> WAIT; if err flag clear, pulse `match[idx]`, `valid`, load `value`=acc; if set, pulse `error` only. Latched non-digit non-terminator (including another key) -> set err flag, stay ARG.
  - IGNORE: latched terminator -> WAIT; everything else discarded. No outputs.
- Duplicate key characters: lowest index wins.
- Empty argument (key immediately followed by terminator): valid command, `value`=0.
- Overflow: accumulator is VALUE_WIDTH+4 bits; if acc*10+digit > 2^VALUE_WIDTH-1, set err flag; remaining digits ignored for arithmetic.
- Leading zeros accepted; no digit-count limit other than overflow.
- No latch activity -> state held indefinitely; no timeout.

## Timing
- Reset values: state WAIT, `match`=0, `valid`=0, `value`=0, `error`=0, accumulator 0.
- Outputs registered: strobes assert exactly 1 cycle after the `clk` edge sampling the terminator with `latch`=1; deassert the next cycle.
- `latch` may be asserted on consecutive cycles; every latched byte processed, no back-pressure.
- `latch`=0: no state change, `in_byte` ignored.
- `match`/`valid` and `error` never asserted in the same cycle.
- Reset mid-packet: immediate return to WAIT, partial packet discarded, no strobe generated; first byte after deassertion is a fresh packet start.

## Configuration
- `CMD_PARSER_HEX_EN` defined: in ARG, an "x" as the first argument byte switches to hex mode; subsequent "0".."9", "a".."f", "A".."F" accumulate acc = acc*16 + nibble; same overflow/terminator rules; "x" with no digits -> `value`=0, valid. "x" anywhere else -> error.
- Not defined: "x" is an ordinary non-digit (error in ARG); decimal only.

## Test plan
- Reset, then "a123\n" with `latch` per byte -> one cycle after "\n": `match`=4'b0001, `valid`=1, `value`=123; `error`=0 throughout.
- "c\r\n" -> `match`=4'b0100, `value`=0; trailing "\n" produces no further strobe; then "z99\n" -> no outputs.
- "b65535\n" then "b65536\n" (VALUE_WIDTH=16) -> first `valid`, `value`=65535; second `error`=1, `value` stays 65535.
- "d12q3\n" -> `error` pulse only; next "a7\n" -> `match`=4'b0001, `value`=7.
- "a45" then `rst` pulse then "6\n" -> no strobes; `value`=0 after reset.
- With `CMD_PARSER_HEX_EN`: "axFF\n" -> `value`=255, `match`=4'b0001; without: same input -> `error`=1.
